divider_arbiter: RTL and testbench
==================================

Name: divider_arbiter

Overview:
- Shares one fixed-latency pipelined divider among NUM_REQ requesters; issues at most one operation per cycle.
- Round-robin arbitration, per-requester outstanding limits, a tag pipeline matched to divider latency, divide-by-zero flagging, and a flush sequence that resets the divider.
- Sits between AFU-side request sources and the divider instance; replaces the AFU's single-shot fixed-wait sequencing.

Parameters:
- DATA_LEN, 32, operand/result width
- NUM_REQ, 4, number of requesters (2..8)
- DIV_LATENCY, 11, cycles from divider operands being registered to result valid on div_result
- MAX_OUTSTANDING, 4, max in-flight operations per requester (1..DIV_LATENCY+1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*DATA_LEN  dividends; requester i at [i*DATA_LEN +: DATA_LEN]
- req_b  in  NUM_REQ*DATA_LEN  divisors, same packing
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i]&req_ready[i]
- flush  in  1  one-cycle pulse; abort all in-flight work
- div_reset  out  1  reset to divider
- div_a  out  DATA_LEN  registered dividend to divider
- div_b  out  DATA_LEN  registered divisor to divider
- div_result  in  DATA_LEN  divider output
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_id  out  $clog2(NUM_REQ)  owning requester
- rsp_result  out  DATA_LEN  quotient
- rsp_dz  out  1  divide-by-zero flag
- busy  out  1  any operation in flight or flush active

Behaviour:
- Reset (async, reset_n low): state=RUN; rr pointer=0; all outstanding counters=0; tag pipe cleared; div_a=div_b=0; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_dz=0; div_reset=1 while reset_n is low.
- States: RUN, FLUSH.
- Eligibility: requester i is eligible in RUN when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Grant: req_ready is combinational. It selects the first eligible requester scanning from the rr pointer upward with wrap-around. req_ready is all-zero in FLUSH or when nothing is eligible.
- Pointer update: after a grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue: on a grant edge, div_a/div_b <= the granted requester's operands, and the tag {valid=1, id, dz=(b==0)} enters tag pipe stage 0. Without a grant, div_a/div_b <= 0 and a tag with valid=0 enters.
- Tag pipe: DIV_LATENCY stages; it advances every cycle.
- Response: when the last tag stage is valid, the next edge loads rsp_valid=1, rsp_id=tag.id and rsp_dz=tag.dz. rsp_result=all-ones if dz, else div_result. Otherwise rsp_valid<=0 and the other rsp fields hold.
- Latency: rsp_valid is high exactly DIV_LATENCY+1 cycles after the accept cycle, and responses return in issue order.
- Counters: outstanding[i] increments on a grant to i and decrements when rsp_valid is loaded for id i. Increment and decrement in the same cycle leave the count unchanged. A counter never exceeds MAX_OUTSTANDING.
- Flush (pulse sampled in RUN):
  - Enter FLUSH for DIV_LATENCY+1 cycles; div_reset=1 throughout.
  - Tag pipe, counters and div_a/div_b are zeroed on entry. No grants, rsp_valid=0.
  - Then return to RUN; the rr pointer is preserved.
  - A flush and a grant in the same cycle: the flush wins, req_ready is forced 0 that cycle, and nothing is accepted.
  - A flush during FLUSH is ignored.
- div_reset: equals (!reset_n) | (state==FLUSH).
- busy: equals any tag valid | rsp_valid | (state==FLUSH).
- Reset mid-operation: everything is discarded immediately and no responses are emitted afterward.

Test Plan:
- Single op: req 0 presents a=100, b=7 → accepted first cycle; rsp_valid exactly 12 cycles later with rsp_id=0, rsp_result=14, rsp_dz=0.
- Round-robin: all 4 requesters held valid for 8 cycles → grants in order 0,1,2,3,0,1,2,3; 8 responses return back-to-back in the same order.
- Outstanding limit: MAX_OUTSTANDING=2, only req 1 valid continuously → 2 accepts, req_ready[1]=0 until the first response, then a new accept the same cycle the counter decrements.
- Divide by zero: req 2 presents a=55, b=0 → rsp_dz=1, rsp_result=0xFFFFFFFF, rsp_id=2.
- Flush: issue 3 ops, pulse flush 5 cycles later → no rsp_valid ever for them; div_reset high 12 cycles; req_ready 0 during that window; a fresh op afterward (a=9, b=3) returns 3.
- Async reset: drop reset_n mid-burst without clk alignment → outputs zero immediately; no stale responses after release.

Source files
------------

// File: rtl/divider_arbiter_if.sv
// Requester-side bus of divider_arbiter.
//   req_valid/req_a/req_b : per-requester operands, packed [i*DATA_LEN +: DATA_LEN]
//   req_ready             : one-hot grant from the arbiter
//   rsp_valid/id/result/dz: one-cycle response strobe, no backpressure
// Handshake: requester i transfers an operation in any cycle where
// req_valid[i] && req_ready[i] are both high at the rising clock edge. A
// requester may raise or drop req_valid freely; req_ready is a combinational
// function of req_valid and internal state and never depends on it staying up.
// Responses are a pure strobe: rsp_valid is high for exactly one cycle per
// accepted operation and cannot be stalled.
interface divider_arbiter_if #(
  parameter int DATA_LEN = 32,
  parameter int NUM_REQ  = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*DATA_LEN-1:0] req_a;
  logic [NUM_REQ*DATA_LEN-1:0] req_b;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        rsp_valid;
  logic [ID_W-1:0]             rsp_id;
  logic [DATA_LEN-1:0]         rsp_result;
  logic                        rsp_dz;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_dz
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_dz
  );
endinterface

// File: rtl/divider_arbiter.sv
// Shares one fixed-latency pipelined divider among NUM_REQ requesters.
// Round-robin grant, per-requester outstanding limit, a tag pipe that tracks
// each operation through the divider, divide-by-zero flagging and a flush
// sequence that holds the divider in reset.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus            : requester-side interface (slave modport)
//   flush          : one-cycle pulse, aborts all in-flight work
//   div_reset      : reset to the divider
//   div_a, div_b   : registered operands to the divider
//   div_result     : divider output, valid DIV_LATENCY cycles after div_a/div_b
//   busy           : work in flight or flush in progress
//   dbg_state      : current FSM state (0 = RUN, 1 = FLUSH)
module divider_arbiter #(
  parameter int DATA_LEN        = 32,
  parameter int NUM_REQ         = 4,
  parameter int DIV_LATENCY     = 11,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  divider_arbiter_if.slave    bus,
  input  logic                flush,
  output logic                div_reset,
  output logic [DATA_LEN-1:0] div_a,
  output logic [DATA_LEN-1:0] div_b,
  input  logic [DATA_LEN-1:0] div_result,
  output logic                busy,
  output logic                dbg_state
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int FC_W  = $clog2(DIV_LATENCY + 1);
  localparam int LAST  = DIV_LATENCY - 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                state, state_next;
  logic [FC_W-1:0]       flush_cnt;
  logic [ID_W-1:0]       ptr;
  logic [CNT_W-1:0]      outstanding [NUM_REQ];
  logic [LAST:0]         tag_valid;
  logic [ID_W-1:0]       tag_id [DIV_LATENCY];
  logic [LAST:0]         tag_dz;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_LEN-1:0]   grant_a, grant_b;
  logic                  flush_go;
  logic                  rsp_load;
  int                    scan_idx;
  logic                  rsp_valid_q, rsp_dz_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic [DATA_LEN-1:0]   rsp_result_q;

  // A flush pulse only counts while running; a pulse during FLUSH is ignored.
  assign flush_go = flush && (state == RUN);
  // The flush edge discards whatever is leaving the tag pipe.
  assign rsp_load = tag_valid[LAST] && !flush_go;

  // Round-robin grant: first eligible requester at or above ptr, wrapping.
  // A flush in the same cycle suppresses the grant so nothing is accepted.
  always_comb begin
    eligible  = '0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
    end
    if (state == RUN && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = (int'(ptr) + k) % NUM_REQ;
        if (!grant_any && eligible[scan_idx]) begin
          grant_any       = 1'b1;
          grant_id        = ID_W'(scan_idx);
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign grant_a = bus.req_a[int'(grant_id)*DATA_LEN +: DATA_LEN];
  assign grant_b = bus.req_b[int'(grant_id)*DATA_LEN +: DATA_LEN];

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_go) state_next = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM state register; flush_cnt counts the DIV_LATENCY+1 FLUSH cycles down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (flush_go)
        flush_cnt <= FC_W'(DIV_LATENCY);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FC_W'(1);
    end
  end

  // Round-robin pointer survives a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (grant_any)
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  end

  // Operand register and tag pipe advance together every cycle so the tag
  // leaving stage LAST lines up with div_result of the same operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_a     <= '0;
      div_b     <= '0;
      tag_valid <= '0;
      tag_dz    <= '0;
      for (int s = 0; s < DIV_LATENCY; s++) tag_id[s] <= '0;
    end else if (flush_go) begin
      div_a     <= '0;
      div_b     <= '0;
      tag_valid <= '0;
      tag_dz    <= '0;
      for (int s = 0; s < DIV_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      div_a        <= grant_any ? grant_a : '0;
      div_b        <= grant_any ? grant_b : '0;
      tag_valid[0] <= grant_any;
      tag_id[0]    <= grant_id;
      tag_dz[0]    <= grant_any && (grant_b == '0);
      for (int s = 1; s < DIV_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
        tag_dz[s]    <= tag_dz[s-1];
      end
    end
  end

  // Response register; id/result/dz hold between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_dz_q     <= 1'b0;
    end else if (rsp_load) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= tag_id[LAST];
      rsp_dz_q     <= tag_dz[LAST];
      rsp_result_q <= tag_dz[LAST] ? '1 : div_result;
    end else begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Outstanding counters: a simultaneous grant and retire cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
    end else if (flush_go) begin
      for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && !(rsp_load && tag_id[LAST] == ID_W'(i)))
          outstanding[i] <= outstanding[i] + CNT_W'(1);
        else if (!grant[i] && rsp_load && tag_id[LAST] == ID_W'(i))
          outstanding[i] <= outstanding[i] - CNT_W'(1);
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_dz     = rsp_dz_q;

  assign div_reset = !reset_n || (state == FLUSH);
  assign busy      = (|tag_valid) || rsp_valid_q || (state == FLUSH);
  assign dbg_state = logic'(state);
endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench for divider_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model that
// tracks accepted operations as a queue of (due cycle, id, result).
module tb_divider_arbiter;
  localparam int W    = 32;
  localparam int NR   = 4;
  localparam int LAT  = 11;
  localparam int MAXO = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic div_reset, busy, dbg_state;
  logic [W-1:0] div_a, div_b, div_result;

  always #5 clk = ~clk;

  divider_arbiter_if #(.DATA_LEN(W), .NUM_REQ(NR)) bus();

  divider_arbiter #(
    .DATA_LEN(W), .NUM_REQ(NR), .DIV_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .flush(flush),
    .div_reset(div_reset), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .busy(busy), .dbg_state(dbg_state)
  );

  // Pipelined divider stand-in: result of the operands seen on div_a/div_b
  // appears LAT cycles later.
  logic [W-1:0] dpipe [LAT-1];
  always_ff @(posedge clk) begin
    if (div_reset) begin
      for (int i = 0; i < LAT-1; i++) dpipe[i] <= '0;
    end else begin
      dpipe[0] <= (div_b == '0) ? '0 : div_a / div_b;
      for (int i = 1; i < LAT-1; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_result = dpipe[LAT-2];

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int           due;
    int           id;
    logic         dz;
    logic [W-1:0] res;
  } rsp_t;

  rsp_t         exp_q[$];
  int           outst [NR];
  int           ptr = 0;
  int           flush_rem = 0;
  int           t = 0;
  logic         exp_rsp;
  rsp_t         cur;
  logic [W-1:0] exp_div_a = '0;
  logic [W-1:0] exp_div_b = '0;
  logic [W-1:0] last_result = '0;
  int           last_id = 0;
  logic         last_dz = 1'b0;
  int           dut_rsp_count = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NR; i++) outst[i] = 0;
    ptr = 0;
    flush_rem = 0;
    exp_div_a = '0;
    exp_div_b = '0;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; runs one full cycle with the given inputs.
  task automatic run_cycle(input logic [NR-1:0] v, input logic [NR*W-1:0] a,
                           input logic [NR*W-1:0] b, input logic fl);
    int g;
    logic in_fl;
    logic [NR-1:0] exp_ready;
    logic [W-1:0] ga, gb, res;
    in_fl   = (flush_rem > 0);
    exp_rsp = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == t) begin
      cur     = exp_q.pop_front();
      exp_rsp = 1'b1;
      outst[cur.id]--;
    end
    @(negedge clk);
    check("rsp_valid", bus.rsp_valid, exp_rsp);
    if (bus.rsp_valid) dut_rsp_count++;
    if (exp_rsp) begin
      check("rsp_id", bus.rsp_id, cur.id);
      check("rsp_result", bus.rsp_result, cur.res);
      check("rsp_dz", bus.rsp_dz, cur.dz);
      last_result = bus.rsp_result;
      last_id     = int'(bus.rsp_id);
      last_dz     = bus.rsp_dz;
    end
    check("busy", busy, in_fl || exp_q.size() > 0 || exp_rsp);
    check("div_reset", div_reset, in_fl);
    check("div_a", div_a, exp_div_a);
    check("div_b", div_b, exp_div_b);

    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    flush         = fl;
    #1;
    g = -1;
    if (!in_fl && !fl) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && v[(ptr+k)%NR] && outst[(ptr+k)%NR] < MAXO) g = (ptr+k) % NR;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", bus.req_ready, exp_ready);

    // effects of the coming edge
    if (in_fl) begin
      flush_rem--;
      exp_div_a = '0;
      exp_div_b = '0;
    end else if (fl) begin
      exp_q.delete();
      for (int i = 0; i < NR; i++) outst[i] = 0;
      flush_rem = LAT + 1;
      exp_div_a = '0;
      exp_div_b = '0;
    end else if (g >= 0) begin
      ga  = a[g*W +: W];
      gb  = b[g*W +: W];
      res = (gb == '0) ? {W{1'b1}} : ga / gb;
      exp_q.push_back('{due: t + LAT + 1, id: g, dz: (gb == '0), res: res});
      outst[g]++;
      ptr = (g + 1) % NR;
      exp_div_a = ga;
      exp_div_b = gb;
    end else begin
      exp_div_a = '0;
      exp_div_b = '0;
    end
    t++;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle('0, '0, '0, 1'b0);
  endtask

  function automatic logic [NR*W-1:0] one_op(input int idx, input logic [W-1:0] val);
    logic [NR*W-1:0] r;
    r = '0;
    r[idx*W +: W] = val;
    return r;
  endfunction

  function automatic logic [NR*W-1:0] rand_dividends();
    logic [NR*W-1:0] r;
    for (int i = 0; i < NR; i++) r[i*W +: W] = $urandom();
    return r;
  endfunction

  function automatic logic [NR*W-1:0] rand_divisors(input bit allow_zero);
    logic [NR*W-1:0] r;
    for (int i = 0; i < NR; i++) begin
      r[i*W +: W] = $urandom_range(1, 4095);
      if (allow_zero && $urandom_range(0, 7) == 0) r[i*W +: W] = '0;
    end
    return r;
  endfunction

  // ---------------- stimulus ----------------
  int rsp_before;

  initial begin
    model_reset();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_result", bus.rsp_result, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_div_reset", div_reset, 1'b1);
    check("reset_div_a", div_a, '0);
    check("reset_req_ready", bus.req_ready, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);

    // single op: 100 / 7
    run_cycle(4'b0001, one_op(0, 32'd100), one_op(0, 32'd7), 1'b0);
    idle(13);
    check("single_result", last_result, 32'd14);
    check("single_id", last_id, 0);

    // round robin: everyone valid for 8 cycles
    for (int i = 0; i < 8; i++) run_cycle('1, rand_dividends(), rand_divisors(1'b0), 1'b0);
    idle(14);

    // outstanding limit: only requester 1
    for (int i = 0; i < 30; i++) run_cycle(4'b0010, rand_dividends(), rand_divisors(1'b0), 1'b0);
    idle(14);

    // divide by zero
    run_cycle(4'b0100, one_op(2, 32'd55), '0, 1'b0);
    idle(13);
    check("dz_result", last_result, 32'hFFFF_FFFF);
    check("dz_flag", last_dz, 1'b1);
    check("dz_id", last_id, 2);

    // flush: three ops in flight, flush 5 cycles later (with a competing
    // request), a second pulse mid-flush, then a fresh op
    rsp_before = dut_rsp_count;
    for (int i = 0; i < 3; i++) run_cycle(4'b0111, rand_dividends(), rand_divisors(1'b0), 1'b0);
    idle(5);
    run_cycle(4'b1000, one_op(3, 32'd77), one_op(3, 32'd5), 1'b1);
    idle(4);
    run_cycle('0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) run_cycle('1, rand_dividends(), rand_divisors(1'b0), 1'b0);
    check("flush_no_rsp", dut_rsp_count, rsp_before);
    idle(15);
    run_cycle(4'b1000, one_op(3, 32'd9), one_op(3, 32'd3), 1'b0);
    idle(13);
    check("post_flush_result", last_result, 32'd3);
    check("post_flush_id", last_id, 3);

    // random traffic
    for (int i = 0; i < 1500; i++)
      run_cycle(NR'($urandom()), rand_dividends(), rand_divisors(1'b1),
                ($urandom_range(0, 59) == 0));
    idle(20);

    // asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) run_cycle('1, rand_dividends(), rand_divisors(1'b1), 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_rsp_valid", bus.rsp_valid, 1'b0);
    check("areset_rsp_result", bus.rsp_result, '0);
    check("areset_busy", busy, 1'b0);
    check("areset_div_reset", div_reset, 1'b1);
    check("areset_div_a", div_a, '0);
    model_reset();
    bus.req_valid = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    rsp_before = dut_rsp_count;
    idle(20);
    check("areset_no_stale", dut_rsp_count, rsp_before);
    for (int i = 0; i < 300; i++)
      run_cycle(NR'($urandom()), rand_dividends(), rand_divisors(1'b1),
                ($urandom_range(0, 59) == 0));
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
